dog_diff_stream: RTL and testbench

Streaming, parametrised difference-of-Gaussian stage for the SIFT pipeline. Accepts one pixel per beat from NUM_SCALES co-registered blur streams (3x3, 5x5, 7x7, …). Emits NUM_SCALES-1 signed differences per beat, tagged with frame and line markers, to the keypoint-layer logic. Uses a valid/ready handshake with full-throughput backpressure and enforces frame geometry with row/column counters.

---
 rtl/sift_pkg.sv | 31 +++
 rtl/dog_diff_stream_if.sv | 33 +++
 rtl/dog_skid_buf.sv | 75 +++++++
 rtl/dog_diff_stream.sv | 128 ++++++++++++
 tb/tb_dog_diff_stream.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sift_pkg.sv
// Shared SIFT pipeline definitions: default frame geometry, the beat marker
// struct and the saturating resize helper used by the DoG stage.
package sift_pkg;

  localparam int DEF_COLS  = 640;
  localparam int DEF_ROWS  = 480;
  localparam int DEF_PIX_W = 9;

  typedef struct packed {
    logic sof;
    logic eol;
    logic eof;
  } marker_t;

  // Clamps v into the signed out_w range when sat_en is set; otherwise v is
  // returned untouched and the caller keeps the low out_w bits (wrap).
  function automatic logic signed [31:0] sat_resize(input logic signed [31:0] v,
                                                    input int                 out_w,
                                                    input bit                 sat_en);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (out_w - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    if (sat_en && (out_w < 32)) begin
      if (v > hi) return hi;
      if (v < lo) return lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/dog_diff_stream_if.sv
// Input and output stream bundle of the DoG stage. The master side is the
// pixel source / result sink; the slave side is the DoG block itself.
interface dog_diff_stream_if
  import sift_pkg::*;
#(
  parameter int PIX_W      = DEF_PIX_W,
  parameter int NUM_SCALES = 4,
  parameter int OUT_W      = 10
);

  logic                              in_valid;
  logic                              in_ready;
  logic                              in_sof;
  logic [NUM_SCALES*PIX_W-1:0]       in_data;
  logic                              out_valid;
  logic                              out_ready;
  logic [(NUM_SCALES-1)*OUT_W-1:0]   out_data;
  logic                              out_sof;
  logic                              out_eol;
  logic                              out_eof;
  logic                              sof_err;

  modport master (
    output in_valid, in_sof, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sof, out_eol, out_eof, sof_err
  );

  modport slave (
    input  in_valid, in_sof, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sof, out_eol, out_eof, sof_err
  );

endinterface

// File: rtl/dog_skid_buf.sv
// One-entry valid/ready skid register: an output register plus a single
// overflow slot. in_ready_o depends only on the skid flop, so the upstream
// never sees a combinational path from out_ready_i. skid_nxt_o exposes the
// next occupancy so the parent can register its own ready ahead of time.
module dog_skid_buf
  import sift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic             skid_nxt_o
);

  logic             out_vld_q, out_vld_d;
  logic             skid_vld_q, skid_vld_d;
  logic [WIDTH-1:0] out_dat_q, out_dat_d;
  logic [WIDTH-1:0] skid_dat_q, skid_dat_d;
  logic             out_free;
  logic             in_fire;

  // Refill the output register from the skid slot first, else from the input;
  // park the input in the skid slot when the output is stalled.
  always_comb begin
    out_free   = !out_vld_q || out_ready_i;
    in_fire    = in_valid_i && !skid_vld_q;
    out_vld_d  = out_vld_q;
    out_dat_d  = out_dat_q;
    skid_vld_d = skid_vld_q;
    skid_dat_d = skid_dat_q;
    if (out_free) begin
      if (skid_vld_q) begin
        out_vld_d  = 1'b1;
        out_dat_d  = skid_dat_q;
        skid_vld_d = 1'b0;
      end else begin
        out_vld_d = in_fire;
        if (in_fire) out_dat_d = in_data_i;
      end
    end else if (in_fire) begin
      skid_vld_d = 1'b1;
      skid_dat_d = in_data_i;
    end
  end

  // Occupancy flags and the visible output word clear on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
      out_dat_q  <= '0;
    end else begin
      out_vld_q  <= out_vld_d;
      skid_vld_q <= skid_vld_d;
      out_dat_q  <= out_dat_d;
    end
  end

  // Skid payload is only meaningful while skid_vld_q is set.
  always_ff @(posedge clk) begin
    skid_dat_q <= skid_dat_d;
  end

  assign in_ready_o  = !skid_vld_q;
  assign out_valid_o = out_vld_q;
  assign out_data_o  = out_dat_q;
  assign skid_nxt_o  = skid_vld_d;

endmodule

// File: rtl/dog_diff_stream.sv
// Streaming difference-of-Gaussian stage. Takes NUM_SCALES co-registered blur
// pixels per beat and emits NUM_SCALES-1 signed adjacent-scale differences,
// tagged with sof/eol/eof from internal column/row counters.
// Build option: define DOG_SAT_EN to clamp differences that do not fit OUT_W;
// by default the low OUT_W bits are kept (two's-complement wrap).
module dog_diff_stream
  import sift_pkg::*;
#(
  parameter int PIX_W      = DEF_PIX_W,
  parameter int NUM_SCALES = 4,
  parameter int OUT_W      = 10,
  parameter int COLS       = DEF_COLS,
  parameter int ROWS       = DEF_ROWS
) (
  input  logic         clk,
  input  logic         rst_n,
  dog_diff_stream_if.slave bus
);

  localparam int DW = (NUM_SCALES - 1) * OUT_W;
  localparam int SW = DW + $bits(marker_t);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);

`ifdef DOG_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic [CW-1:0] col_q, col_d, pos_col;
  logic [RW-1:0] row_q, row_d, pos_row;
  logic          in_ready_q, in_ready_d;
  logic          sof_err_q, sof_err_d;
  logic          vld_p1_q, vld_p1_d;
  logic [DW-1:0] dat_p1_q, dat_p1_d;
  marker_t       mrk_p1_q, mrk_p1_d;
  logic [DW-1:0] diff;
  marker_t       mrk;
  logic          accept;
  logic          s1_en;
  logic          s2_ready;
  logic          skid_nxt;
  logic [SW-1:0] s2_out;

  // Adjacent-scale subtract: exact in PIX_W+1 signed bits, then resized.
  for (genvar k = 0; k < NUM_SCALES - 1; k++) begin : g_diff
    logic signed [PIX_W:0] raw;
    assign raw = $signed({1'b0, bus.in_data[k*PIX_W +: PIX_W]})
               - $signed({1'b0, bus.in_data[(k+1)*PIX_W +: PIX_W]});
    assign diff[k*OUT_W +: OUT_W] = OUT_W'(sat_resize(32'(raw), OUT_W, SAT_EN));
  end

  // Beat position, markers, counter advance and the S1 load decision.
  always_comb begin
    accept   = bus.in_valid && in_ready_q;
    pos_col  = bus.in_sof ? '0 : col_q;
    pos_row  = bus.in_sof ? '0 : row_q;
    mrk.sof  = (pos_col == '0) && (pos_row == '0);
    mrk.eol  = (pos_col == CW'(COLS - 1));
    mrk.eof  = mrk.eol && (pos_row == RW'(ROWS - 1));
    col_d    = col_q;
    row_d    = row_q;
    if (accept) begin
      if (mrk.eol) begin
        col_d = '0;
        row_d = mrk.eof ? '0 : pos_row + 1'b1;
      end else begin
        col_d = pos_col + 1'b1;
        row_d = pos_row;
      end
    end
    sof_err_d = accept && bus.in_sof && ((col_q != '0) || (row_q != '0));
    s1_en     = !vld_p1_q || s2_ready;
    vld_p1_d  = s1_en ? accept : vld_p1_q;
    dat_p1_d  = dat_p1_q;
    mrk_p1_d  = mrk_p1_q;
    if (s1_en && accept) begin
      dat_p1_d = diff;
      mrk_p1_d = mrk;
    end
    // Ready next cycle only if S1 will be free to load then.
    in_ready_d = !vld_p1_d || !skid_nxt;
  end

  // ---- S0 -> S1 boundary: control state ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q      <= '0;
      row_q      <= '0;
      in_ready_q <= 1'b0;
      sof_err_q  <= 1'b0;
      vld_p1_q   <= 1'b0;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      in_ready_q <= in_ready_d;
      sof_err_q  <= sof_err_d;
      vld_p1_q   <= vld_p1_d;
    end
  end

  // S1 payload, qualified by vld_p1_q.
  always_ff @(posedge clk) begin
    dat_p1_q <= dat_p1_d;
    mrk_p1_q <= mrk_p1_d;
  end

  // ---- S1 -> S2 boundary: output register plus skid slot ----
  dog_skid_buf #(
    .WIDTH (SW)
  ) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (vld_p1_q),
    .in_ready_o  (s2_ready),
    .in_data_i   ({mrk_p1_q, dat_p1_q}),
    .out_valid_o (bus.out_valid),
    .out_ready_i (bus.out_ready),
    .out_data_o  (s2_out),
    .skid_nxt_o  (skid_nxt)
  );

  assign {bus.out_sof, bus.out_eol, bus.out_eof, bus.out_data} = s2_out;
  assign bus.in_ready = in_ready_q;
  assign bus.sof_err  = sof_err_q;

endmodule

// File: tb/tb_dog_diff_stream.sv
// Bench for dog_diff_stream: a small-geometry instance (4x2 frame) checked
// against a queue-based reference model, plus a two-scale OUT_W=8 instance for
// the resize corner cases.
module tb_dog_diff_stream;

  localparam int PIX_W = 9;
  localparam int NS    = 4;
  localparam int OUT_W = 10;
  localparam int COLS  = 4;
  localparam int ROWS  = 2;
  localparam int IW    = NS * PIX_W;

`ifdef DOG_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  dog_diff_stream_if #(.PIX_W(PIX_W), .NUM_SCALES(NS), .OUT_W(OUT_W)) ifa ();
  dog_diff_stream_if #(.PIX_W(PIX_W), .NUM_SCALES(2),  .OUT_W(8))     ifb ();

  dog_diff_stream #(
    .PIX_W(PIX_W), .NUM_SCALES(NS), .OUT_W(OUT_W), .COLS(COLS), .ROWS(ROWS)
  ) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa)
  );

  dog_diff_stream #(
    .PIX_W(PIX_W), .NUM_SCALES(2), .OUT_W(8), .COLS(COLS), .ROWS(ROWS)
  ) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb)
  );

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference arithmetic: exact difference, optional clamp, keep low w bits.
  function automatic int resize_ref(input int v, input int w, input bit sat);
    int lim;
    lim = 1 << (w - 1);
    if (sat) begin
      if (v > lim - 1) v = lim - 1;
      if (v < -lim)    v = -lim;
    end
    return v & ((1 << w) - 1);
  endfunction

  // Expected {diffs, sof, eol, eof} for a beat at linear frame position pos.
  function automatic logic [63:0] expect_beat(input logic [IW-1:0] d, input int pos);
    logic [63:0] r;
    int a, b, v;
    r = '0;
    for (int k = 0; k < NS - 1; k++) begin
      a = int'(d[k*PIX_W +: PIX_W]);
      b = int'(d[(k+1)*PIX_W +: PIX_W]);
      v = resize_ref(a - b, OUT_W, SAT);
      r[3 + k*OUT_W +: OUT_W] = v[OUT_W-1:0];
    end
    r[2] = (pos == 0);
    r[1] = ((pos % COLS) == COLS - 1);
    r[0] = (pos == COLS * ROWS - 1);
    return r;
  endfunction

  function automatic logic [63:0] obs_a();
    return 64'({ifa.out_data, ifa.out_sof, ifa.out_eol, ifa.out_eof});
  endfunction

  function automatic logic [IW-1:0] rand_pix();
    return IW'({$urandom(), $urandom()});
  endfunction

  // Reference model state, owned by the monitor except while in reset.
  logic [63:0] q[$];
  int          pos_m = 0;
  bit          exp_err = 1'b0;
  bit          stall_prev = 1'b0;
  logic [63:0] snap = '0;
  int          err_seen = 0;
  bit          mon_en = 1'b0;

  always @(negedge clk) begin
    logic [63:0] obs;
    logic [63:0] exp_beat;
    int          p;
    if (mon_en && rst_n) begin
      check("sof_err", 64'(ifa.sof_err), 64'(exp_err));
      if (ifa.sof_err) err_seen++;
      exp_err = 1'b0;
      obs = obs_a();
      if (stall_prev) begin
        check("stall_valid", 64'(ifa.out_valid), 64'd1);
        check("stall_data", obs, snap);
      end
      if (ifa.out_valid && ifa.out_ready) begin
        check("out_beat_expected", 64'(q.size() != 0), 64'd1);
        if (q.size() != 0) begin
          exp_beat = q.pop_front();
          check("out_beat", obs, exp_beat);
        end
      end
      if (ifa.in_valid && ifa.in_ready) begin
        p = ifa.in_sof ? 0 : pos_m;
        if (ifa.in_sof && pos_m != 0) exp_err = 1'b1;
        q.push_back(expect_beat(ifa.in_data, p));
        pos_m = (p + 1) % (COLS * ROWS);
      end
      stall_prev = ifa.out_valid && !ifa.out_ready;
      snap = obs;
    end
  end

  task automatic check_idle(input string tag);
    check({tag, "_a"}, 64'({ifa.in_ready, ifa.out_valid, ifa.sof_err, ifa.out_sof,
                            ifa.out_eol, ifa.out_eof, ifa.out_data}), 64'd0);
    check({tag, "_b"}, 64'({ifb.in_ready, ifb.out_valid, ifb.sof_err, ifb.out_sof,
                            ifb.out_eol, ifb.out_eof, ifb.out_data}), 64'd0);
  endtask

  // Present one beat on A and hold it until accepted (bounded).
  task automatic send_beat(input logic [IW-1:0] d, input bit sof);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    ifa.in_valid = 1'b1;
    ifa.in_data  = d;
    ifa.in_sof   = sof;
    while (!done && n < 100) begin
      @(negedge clk);
      done = ifa.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    ifa.in_valid = 1'b0;
    ifa.in_sof   = 1'b0;
    check("send_accept", 64'(done), 64'd1);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    ifa.out_ready = 1'b1;
    while (q.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    check(tag, 64'(q.size()), 64'd0);
  endtask

  initial begin
    bit acc;
    int sent, cyc, errs0, n;
    bit found;
    bit rdy_exp [8];

    ifa.in_valid = 1'b0; ifa.in_sof = 1'b0; ifa.in_data = '0; ifa.out_ready = 1'b1;
    ifb.in_valid = 1'b0; ifb.in_sof = 1'b0; ifb.in_data = '0; ifb.out_ready = 1'b1;

    // Reset values
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    rst_n = 1'b1;
    #1;
    check("ready_before_edge", 64'(ifa.in_ready), 64'd0);
    @(posedge clk);
    #1;
    check("ready_after_edge_a", 64'(ifa.in_ready), 64'd1);
    check("ready_after_edge_b", 64'(ifb.in_ready), 64'd1);
    mon_en = 1'b1;

    // 16 continuous beats over a 4x2 frame; output beat j-2 visible in iteration j
    for (int j = 0; j < 18; j++) begin
      if (j < 16) begin
        ifa.in_valid = 1'b1;
        ifa.in_sof   = (j == 0);
        ifa.in_data  = rand_pix();
      end else begin
        ifa.in_valid = 1'b0;
        ifa.in_sof   = 1'b0;
      end
      if (j >= 2) begin
        check($sformatf("markers_beat%0d", j - 2),
              64'({ifa.out_valid, ifa.out_sof, ifa.out_eol, ifa.out_eof}),
              64'({1'b1, ((j - 2) % 8) == 0, ((j - 2) % 4) == 3, ((j - 2) % 8) == 7}));
      end
      @(posedge clk);
      #1;
    end

    // Difference values and two-edge latency
    ifa.in_valid = 1'b1; ifa.in_sof = 1'b1;
    ifa.in_data  = {9'd5, 9'd6, 9'd6, 9'd5};
    ifb.in_valid = 1'b1; ifb.in_sof = 1'b1;
    ifb.in_data  = {9'd10, 9'd300};
    @(posedge clk);
    #1;
    ifa.in_valid = 1'b0; ifa.in_sof = 1'b0;
    ifb.in_data  = {9'd300, 9'd10};
    ifb.in_sof   = 1'b0;
    check("latency_one_edge_a", 64'(ifa.out_valid), 64'd0);
    check("latency_one_edge_b", 64'(ifb.out_valid), 64'd0);
    @(posedge clk);
    #1;
    ifb.in_valid = 1'b0;
    check("diff_5665", 64'({ifa.out_valid, ifa.out_data}), 64'({1'b1, 10'h001, 10'h000, 10'h3FF}));
`ifdef DOG_SAT_EN
    check("resize_300_10", 64'({ifb.out_valid, ifb.out_data}), 64'({1'b1, 8'h7F}));
`else
    check("resize_300_10", 64'({ifb.out_valid, ifb.out_data}), 64'({1'b1, 8'h22}));
`endif
    @(posedge clk);
    #1;
`ifdef DOG_SAT_EN
    check("resize_10_300", 64'({ifb.out_valid, ifb.out_data}), 64'({1'b1, 8'h80}));
`else
    check("resize_10_300", 64'({ifb.out_valid, ifb.out_data}), 64'({1'b1, 8'hDE}));
`endif
    drain("drain_directed");

    // One stalled cycle with an empty skid: one more beat absorbed, then ready drops
    rdy_exp = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    ifa.in_valid = 1'b1;
    ifa.in_data  = rand_pix();
    for (int c = 0; c < 8; c++) begin
      ifa.out_ready = (c != 3);
      @(negedge clk);
      acc = ifa.in_valid && ifa.in_ready;
      @(posedge clk);
      #1;
      if (acc) ifa.in_data = rand_pix();
      check($sformatf("ready_stall_c%0d", c), 64'(ifa.in_ready), 64'(rdy_exp[c]));
    end
    ifa.in_valid = 1'b0;
    drain("drain_stall");

    // 1000 beats under random out_ready
    sent = 0;
    cyc  = 0;
    acc  = 1'b0;
    while (sent < 1000 && cyc < 20000) begin
      if (acc) sent++;
      if (!ifa.in_valid || acc) begin
        if (sent < 1000 && $urandom_range(0, 3) != 0) begin
          ifa.in_valid = 1'b1;
          ifa.in_data  = rand_pix();
        end else begin
          ifa.in_valid = 1'b0;
        end
      end
      ifa.out_ready = $urandom_range(0, 1) != 0;
      @(negedge clk);
      acc = ifa.in_valid && ifa.in_ready;
      @(posedge clk);
      #1;
      cyc++;
    end
    ifa.in_valid = 1'b0;
    check("random_sent", 64'(sent), 64'd1000);
    drain("drain_random");

    // Early sof at (2,0)
    n = 0;
    while (pos_m != 0 && n < 16) begin
      send_beat(rand_pix(), 1'b0);
      n++;
    end
    errs0 = err_seen;
    send_beat(rand_pix(), 1'b0);
    send_beat(rand_pix(), 1'b0);
    send_beat(rand_pix(), 1'b1);
    send_beat(rand_pix(), 1'b0);
    drain("drain_sof_err");
    check("sof_err_pulses", 64'(err_seen - errs0), 64'd1);

    // Reset mid-line with out_ready low
    ifa.out_ready = 1'b0;
    send_beat(rand_pix(), 1'b0);
    send_beat(rand_pix(), 1'b0);
    @(posedge clk);
    #1;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #2;
    check_idle("midreset");
    @(posedge clk);
    #1;
    check_idle("midreset_edge");
    rst_n = 1'b1;
    q.delete();
    pos_m      = 0;
    exp_err    = 1'b0;
    stall_prev = 1'b0;
    mon_en     = 1'b1;
    ifa.out_ready = 1'b1;
    send_beat(rand_pix(), 1'b0);
    found = 1'b0;
    n = 0;
    while (!found && n < 10) begin
      @(negedge clk);
      found = ifa.out_valid;
      n++;
    end
    check("post_reset_out", 64'(found), 64'd1);
    check("post_reset_sof", 64'(ifa.out_sof), 64'd1);
    drain("drain_final");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
